// File: rtl/noise_ma_filter.sv
// Streaming moving-average filter: mean of the last 2^LOG2N accepted signed samples.
// Optional macro NOISE_MA_WARMUP_EN suppresses outputs until the window is first filled.
module noise_ma_filter #(
  parameter int W     = 16,
  parameter int LOG2N = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] s_axi_tdata,
  input  logic         s_axi_tvalid,
  output logic         s_axi_tready,
  output logic [W-1:0] m_axi_tdata,
  output logic         m_axi_tvalid,
  input  logic         m_axi_tready
);

  localparam int N  = 1 << LOG2N;
  localparam int SW = W + LOG2N;

  logic [W-1:0]          buf_reg [N];
  logic [LOG2N-1:0]      wptr_reg;
  logic signed [SW-1:0]  sum_reg;
  logic signed [SW-1:0]  sum_next;
  logic signed [SW-1:0]  in_ext;
  logic signed [SW-1:0]  old_ext;
  logic [W-1:0]          old;
  logic [W-1:0]          mean_next;
  logic [N-1:0]          wen;
  logic                  accept;
  logic                  produce;

  assign s_axi_tready = !m_axi_tvalid || m_axi_tready;
  assign accept       = s_axi_tvalid && s_axi_tready;

  // Register-based buffer so the outgoing sample is read combinationally in the accept cycle.
  assign old     = buf_reg[wptr_reg];
  assign in_ext  = {{LOG2N{s_axi_tdata[W-1]}}, s_axi_tdata};
  assign old_ext = {{LOG2N{old[W-1]}}, old};
  assign sum_next = sum_reg + in_ext - old_ext;

  // Arithmetic shift gives floor division; the mean of W-bit values always fits in W bits.
  assign mean_next = W'(sum_next >>> LOG2N);

  for (genvar gi = 0; gi < N; gi++) begin : g_wen
    assign wen[gi] = accept && (wptr_reg == LOG2N'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!reset_n) begin
        buf_reg[i] <= '0;
      end else if (wen[i]) begin
        buf_reg[i] <= s_axi_tdata;
      end
    end
  end

`ifdef NOISE_MA_WARMUP_EN
  logic [LOG2N:0] fill_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fill_reg <= '0;
    end else if (accept && (fill_reg != (LOG2N+1)'(N))) begin
      fill_reg <= fill_reg + (LOG2N+1)'(1);
    end
  end

  // The accept that completes the first full window is the first one to emit.
  assign produce = accept && (fill_reg >= (LOG2N+1)'(N - 1));
`else
  assign produce = accept;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum_reg      <= '0;
      wptr_reg     <= '0;
      m_axi_tdata  <= '0;
      m_axi_tvalid <= 1'b0;
    end else begin
      if (accept) begin
        sum_reg  <= sum_next;
        wptr_reg <= wptr_reg + LOG2N'(1);
      end
      if (produce) begin
        m_axi_tdata  <= mean_next;
        m_axi_tvalid <= 1'b1;
      end else if (m_axi_tready) begin
        m_axi_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_noise_ma_filter.sv
// Self-checking bench for noise_ma_filter against a sliding-window mean model.
// Honours NOISE_MA_WARMUP_EN when the same macro is defined for the build.
module tb_noise_ma_filter;

  localparam int W     = 16;
  localparam int LOG2N = 3;
  localparam int N     = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] s_axi_tdata = '0;
  logic         s_axi_tvalid = 1'b0;
  logic         s_axi_tready;
  logic [W-1:0] m_axi_tdata;
  logic         m_axi_tvalid;
  logic         m_axi_tready = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  int           win[$];
  int           n_acc;
  logic         exp_valid;
  logic [W-1:0] exp_data;

  noise_ma_filter #(.W(W), .LOG2N(LOG2N)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_axi_tdata  (s_axi_tdata),
    .s_axi_tvalid (s_axi_tvalid),
    .s_axi_tready (s_axi_tready),
    .m_axi_tdata  (m_axi_tdata),
    .m_axi_tvalid (m_axi_tvalid),
    .m_axi_tready (m_axi_tready)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    win.delete();
    for (int i = 0; i < N; i++) win.push_back(0);
    n_acc     = 0;
    exp_valid = 1'b0;
    exp_data  = '0;
  endtask

  // Window mean computed from the last N samples, floored toward minus infinity.
  task automatic model_push(input logic [W-1:0] d, output bit prod, output logic [W-1:0] mean);
    int s;
    int q;
    void'(win.pop_front());
    win.push_back(int'($signed(d)));
    n_acc++;
    s = 0;
    foreach (win[i]) s += win[i];
    q = s / N;
    if ((s % N) != 0 && s < 0) q -= 1;
    mean = q[W-1:0];
`ifdef NOISE_MA_WARMUP_EN
    prod = (n_acc >= N);
`else
    prod = 1'b1;
`endif
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic rdy, output logic rs);
    @(negedge clk);
    s_axi_tvalid = v;
    s_axi_tdata  = d;
    m_axi_tready = rdy;
    #1;
    rs = s_axi_tready;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [W-1:0] d, input logic rdy, output bit acc);
    logic         rs;
    bit           hs;
    bit           prod;
    logic [W-1:0] mean;
    hs = exp_valid && rdy;
    step(1'b1, d, rdy, rs);
    acc  = (rs === 1'b1);
    prod = 1'b0;
    mean = '0;
    if (acc) begin
      model_push(d, prod, mean);
      $display("accept in=%0d emits=%0d expected_out=%0d", $signed(d), prod, $signed(mean));
    end
    if (prod) begin
      exp_valid = 1'b1;
      exp_data  = mean;
    end else if (hs) begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n      = 1'b0;
    s_axi_tvalid = 1'b0;
    m_axi_tready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    s_axi_tvalid = 1'b1;
    s_axi_tdata  = 16'h1234;
    m_axi_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (m_axi_tvalid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b expected 0", m_axi_tvalid);
    end
    n_vec++;
    if (m_axi_tdata !== '0) begin
      n_err++; $display("FAIL reset_data: got %h expected 0000", m_axi_tdata);
    end
    n_vec++;
    if (s_axi_tready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b expected 1", s_axi_tready);
    end
    @(negedge clk);
    reset_n      = 1'b1;
    s_axi_tvalid = 1'b0;
    m_axi_tready = 1'b1;
    model_reset();
  endtask

  task automatic test_ramp();
    bit acc;
    do_reset();
    for (int i = 0; i < N; i++) begin
      feed(16'd800, 1'b1, acc);
      n_vec++;
      if (!acc) begin
        n_err++; $display("FAIL ramp_accept[%0d]: got 0 expected 1", i);
      end
      n_vec++;
      if (m_axi_tvalid !== exp_valid || (exp_valid && m_axi_tdata !== exp_data)) begin
        n_err++;
        $display("FAIL ramp_out[%0d]: got v=%b d=%0d expected v=%b d=%0d",
                 i, m_axi_tvalid, $signed(m_axi_tdata), exp_valid, $signed(exp_data));
      end
    end
    n_vec++;
    if (m_axi_tvalid !== 1'b1 || m_axi_tdata !== 16'd800) begin
      n_err++; $display("FAIL ramp_final: got v=%b d=%0d expected v=1 d=800", m_axi_tvalid, $signed(m_axi_tdata));
    end
  endtask

  task automatic test_step_down();
    bit acc;
    for (int i = 0; i < N; i++) begin
      feed(16'd0, 1'b1, acc);
      n_vec++;
      if (!acc || m_axi_tvalid !== 1'b1 || m_axi_tdata !== exp_data) begin
        n_err++;
        $display("FAIL step_out[%0d]: got acc=%b v=%b d=%0d expected acc=1 v=1 d=%0d",
                 i, acc, m_axi_tvalid, $signed(m_axi_tdata), $signed(exp_data));
      end
    end
    n_vec++;
    if (m_axi_tdata !== 16'd0) begin
      n_err++; $display("FAIL step_final: got %0d expected 0", $signed(m_axi_tdata));
    end
  endtask

  task automatic test_floor();
    bit acc;
    do_reset();
    feed(16'hFFFF, 1'b1, acc);
`ifndef NOISE_MA_WARMUP_EN
    n_vec++;
    if (m_axi_tvalid !== 1'b1 || m_axi_tdata !== 16'hFFFF) begin
      n_err++; $display("FAIL floor_neg1: got v=%b d=%0d expected v=1 d=-1", m_axi_tvalid, $signed(m_axi_tdata));
    end
`endif
    for (int i = 1; i < N; i++) begin
      feed(16'd0, 1'b1, acc);
      n_vec++;
      if (m_axi_tvalid !== exp_valid || (exp_valid && m_axi_tdata !== exp_data)) begin
        n_err++;
        $display("FAIL floor_out[%0d]: got v=%b d=%0d expected v=%b d=%0d",
                 i, m_axi_tvalid, $signed(m_axi_tdata), exp_valid, $signed(exp_data));
      end
    end
  endtask

  task automatic test_extremes();
    bit           acc;
    logic [W-1:0] vals [2];
    vals[0] = 16'h7FFF;
    vals[1] = 16'h8000;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < N; i++) begin
        feed(vals[p], 1'b1, acc);
        n_vec++;
        if (m_axi_tvalid !== exp_valid || (exp_valid && m_axi_tdata !== exp_data)) begin
          n_err++;
          $display("FAIL extreme_out[%0d.%0d]: got v=%b d=%0d expected v=%b d=%0d",
                   p, i, m_axi_tvalid, $signed(m_axi_tdata), exp_valid, $signed(exp_data));
        end
      end
      n_vec++;
      if (m_axi_tdata !== vals[p]) begin
        n_err++; $display("FAIL extreme_final[%0d]: got %0d expected %0d", p, $signed(m_axi_tdata), $signed(vals[p]));
      end
    end
  endtask

  task automatic test_backpressure();
    bit           acc;
    logic         rs;
    logic [W-1:0] held;
    do_reset();
    for (int i = 0; i < N; i++) feed(16'd800, 1'b1, acc);
    held = m_axi_tdata;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'($urandom), 1'b0, rs);
      n_vec++;
      if (rs !== 1'b0) begin
        n_err++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, rs);
      end
      n_vec++;
      if (m_axi_tvalid !== 1'b1 || m_axi_tdata !== held || held !== 16'd800) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v=%b d=%0d expected v=1 d=800", i, m_axi_tvalid, $signed(m_axi_tdata));
      end
    end
    feed(16'd400, 1'b1, acc);
    n_vec++;
    if (!acc) begin
      n_err++; $display("FAIL bp_release_accept: got 0 expected 1");
    end
    n_vec++;
    if (m_axi_tvalid !== 1'b1 || m_axi_tdata !== exp_data || exp_data !== 16'd750) begin
      n_err++; $display("FAIL bp_release_out: got v=%b d=%0d expected v=1 d=750", m_axi_tvalid, $signed(m_axi_tdata));
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    do_reset();
    for (int i = 0; i < 3; i++) feed(16'd800, 1'b1, acc);
    @(negedge clk);
    reset_n      = 1'b0;
    s_axi_tvalid = 1'b1;
    s_axi_tdata  = 16'd800;
    m_axi_tready = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (m_axi_tvalid !== 1'b0 || m_axi_tdata !== '0) begin
      n_err++; $display("FAIL midreset_clear: got v=%b d=%0d expected v=0 d=0", m_axi_tvalid, $signed(m_axi_tdata));
    end
    @(negedge clk);
    reset_n      = 1'b1;
    s_axi_tvalid = 1'b0;
    m_axi_tready = 1'b1;
    model_reset();
    feed(16'd800, 1'b1, acc);
    n_vec++;
    if (m_axi_tvalid !== exp_valid || (exp_valid && m_axi_tdata !== exp_data)) begin
      n_err++;
      $display("FAIL midreset_next: got v=%b d=%0d expected v=%b d=%0d",
               m_axi_tvalid, $signed(m_axi_tdata), exp_valid, $signed(exp_data));
    end
`ifndef NOISE_MA_WARMUP_EN
    n_vec++;
    if (m_axi_tdata !== 16'd100) begin
      n_err++; $display("FAIL midreset_100: got %0d expected 100", $signed(m_axi_tdata));
    end
`endif
  endtask

  task automatic test_random();
    logic         v;
    logic         rdy;
    logic         rs;
    logic         exp_rdy;
    logic [W-1:0] d;
    logic [W-1:0] mean;
    bit           hs;
    bit           prod;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      v       = ($urandom_range(0, 3) != 0);
      rdy     = ($urandom_range(0, 3) != 0);
      d       = 16'($urandom);
      hs      = exp_valid && rdy;
      exp_rdy = !exp_valid || rdy;
      step(v, d, rdy, rs);
      n_vec++;
      if (rs !== exp_rdy) begin
        n_err++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, rs, exp_rdy);
      end
      prod = 1'b0;
      mean = '0;
      if (v && exp_rdy) begin
        model_push(d, prod, mean);
        $display("accept in=%0d emits=%0d expected_out=%0d", $signed(d), prod, $signed(mean));
      end
      if (prod) begin
        exp_valid = 1'b1;
        exp_data  = mean;
      end else if (hs) begin
        exp_valid = 1'b0;
      end
      n_vec++;
      if (m_axi_tvalid !== exp_valid || (exp_valid && m_axi_tdata !== exp_data)) begin
        n_err++;
        $display("FAIL rand_out[%0d]: got v=%b d=%0d expected v=%b d=%0d",
                 i, m_axi_tvalid, $signed(m_axi_tdata), exp_valid, $signed(exp_data));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ramp();
    test_step_down();
    test_floor();
    test_extremes();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/noise_ma_filter.md
# noise_ma_filter

Streaming moving-average filter on the noisy measurement path, directly upstream of the PID controller. Its master stream drives the controller's `s_axi_*` measurement input. It accepts one signed W-bit sample per handshake and outputs the arithmetic mean of the last 2^LOG2N accepted samples. This suppresses sensor noise before the error term is formed.

## Interface
- `W`, 16, sample width; signed two's complement in and out.
- `LOG2N`, 3, log2 of the window length N = 2^LOG2N; legal range 1..5.
- Clock and reset are fixed: one clock, `clk`; reset `reset_n` is synchronous and active-low.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `s_axi_tdata`  in  W  signed input sample.
- `s_axi_tvalid`  in  1  input sample valid.
- `s_axi_tready`  out  1  filter can accept a sample this cycle.
- `m_axi_tdata`  out  W  signed filtered sample, feeds the PID measurement input.
- `m_axi_tvalid`  out  1  output sample valid.
- `m_axi_tready`  in  1  downstream accepts the output sample.

## Operation
- Storage and counters:
  - N-entry circular buffer of W-bit samples.
  - Write pointer `wptr` of LOG2N bits.
  - Signed running sum of W+LOG2N bits.
  - Warm-up counter, LOG2N+1 bits, saturating at N.
- Accept condition: `s_axi_tvalid && s_axi_tready`. Nothing changes on non-accept cycles.
- On accept:
  - `old = buf[wptr]`, then `buf[wptr] <= s_axi_tdata`.
  - `sum <= sum + s_axi_tdata - old`, using sign-extended operands.
  - `wptr` increments and wraps from N-1 to 0.
- Output register: `m_axi_tdata <= (sum + s_axi_tdata - old) >>> LOG2N`. This is an arithmetic shift, so the result is floor division.
  - The result always fits in W bits, because the mean of W-bit values stays in W-bit range.
  - No saturation logic is required.
- Output valid: `m_axi_tvalid` sets on an accept. It clears on an output handshake with no simultaneous accept.
- Ready: `s_axi_tready = !m_axi_tvalid || m_axi_tready`, combinational. This gives a single output register with pass-through ready.
- Simultaneous output handshake and new accept: the output register is overwritten with the new mean and `m_axi_tvalid` stays 1.
- Held data: while `m_axi_tvalid && !m_axi_tready`, `m_axi_tdata` stays stable and no input is accepted.
- Reset (`reset_n` low at a clock edge), whenever it occurs including mid-stream or with an output pending:
  - Buffer entries, `sum`, `wptr` and the warm-up counter are all cleared to 0.
  - `m_axi_tvalid` = 0 and `m_axi_tdata` = 0.
  - Any pending output is discarded.
- Reset values of outputs: `m_axi_tvalid` 0, `m_axi_tdata` 0. `s_axi_tready` reads 1 whenever `m_axi_tvalid` is 0, including during reset.

## Timing
- Latency: the output appears one cycle after the accepting edge. `m_axi_tvalid` is high in the cycle following the accept.
- Throughput: one sample per cycle while `m_axi_tready` = 1.
- No combinational path from `s_axi_tdata` to `m_axi_tdata`. The only combinational path is `m_axi_tready` to `s_axi_tready`.
- Buffer read of `old` is combinational from `wptr` within the accept cycle. The buffer is register-based, not block RAM.

## Configuration
- Macro: `NOISE_MA_WARMUP_EN`.
- Defined:
  - The first N-1 accepted samples after reset update `buf`, `sum` and the counter, but do not set `m_axi_tvalid`.
  - The first output is produced on the Nth accept. After that, every accept produces an output.
- Undefined:
  - Every accept produces an output from the first sample.
  - Unfilled entries count as 0, so early outputs ramp up from zero.
  - The warm-up counter is not instantiated.

## Test plan
All scenarios use W=16, LOG2N=3, and hold `m_axi_tready` = 1 unless stated otherwise.
- Ramp: reset, then 8 × 800 back-to-back.
  - Macro off: outputs 100, 200, …, 800, one per cycle.
  - Macro on: a single output of 800 after the 8th accept.
- Step down: after 8 × 800, feed 8 × 0. Outputs are 700, 600, …, 0, and the sum returns exactly to 0.
- Floor rounding, macro off: reset, then a single -1. The output is -1 (floor of -1/8), not 0.
- Extremes: 8 × 32767 produces 32767, then 8 × -32768 produces -32768, with no wrap.
- Backpressure:
  - After one output, hold `m_axi_tready` = 0 for 5 cycles with `s_axi_tvalid` = 1. `s_axi_tready` stays 0 and `m_axi_tdata` stays constant.
  - Release: the output handshakes and the next sample is accepted in that same cycle.
- Reset mid-stream, macro off: after 3 × 800, pulse `reset_n` low for one cycle while an output is pending.
  - `m_axi_tvalid` goes to 0.
  - The next 800 then produces 100.
